pe_conv_ctrl: RTL and testbench

- Sequencer for the 3x3 convolution PE array: one job = one strip of IMG_ROW output rows over cfg_cols image columns and all input channels.
- Issues image/weight buffer read addresses.
- Generates per-row start/clear strobes, skewed one clock per row.
- Collects per-row done flags and reports job completion.
- Sits between the layer-level control/buffer logic and the PE array.

---
 rtl/pe_pkg.sv | 26 ++
 rtl/skew_line.sv | 36 +++
 rtl/pe_conv_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pe_conv_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the 3x3 convolution PE-array sequencer.
package pe_pkg;

  localparam int unsigned KERNEL_SIZE = 3;
  localparam int unsigned CNT_W       = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  // Packed code 0 is the plain 3-channel input; other codes are 2^(code+2) channels.
  function automatic logic [CNT_W-1:0] chan_count(input logic [2:0] packed_code);
    logic [CNT_W-1:0] count;
    if (packed_code == 3'd0) begin
      count = CNT_W'(KERNEL_SIZE);
    end else begin
      count = CNT_W'(1) << ({1'b0, packed_code} + 4'd2);
    end
    return count;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Tapped shift register: bit i of taps is din delayed i+1 cycles; flush empties it.
module skew_line #(
  parameter int DEPTH = 54
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             din,
  output logic [DEPTH-1:0] taps
);

  logic [DEPTH-1:0] taps_d;
  logic [DEPTH-1:0] taps_q;

  // Shift in the new strobe, or drop everything in flight on flush.
  always_comb begin
    taps_d = taps_q;
    if (flush) begin
      taps_d = '0;
    end else begin
      taps_d = (taps_q << 1) | DEPTH'(din);
    end
  end

  // Tap register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_q <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign taps = taps_q;

endmodule

// File: rtl/pe_conv_ctrl.sv
// Job sequencer for the convolution PE array: buffer read addresses, skewed
// per-row start/clear strobes and collection of per-row done flags.
module pe_conv_ctrl
  import pe_pkg::*;
#(
  parameter int IMG_ROW = 54,
  parameter int COL_W   = 8,
  parameter int ADDR_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_start,
  input  logic               cfg_abort,
  input  logic [2:0]         channel_packed,
  input  logic [COL_W-1:0]   cfg_cols,
  input  logic               buf_ready,
  output logic               rd_valid,
  output logic [ADDR_W-1:0]  img_addr,
  output logic [ADDR_W-1:0]  wgt_addr,
  output logic [IMG_ROW-1:0] pe_start,
  output logic [IMG_ROW-1:0] pe_clear,
  input  logic [IMG_ROW-1:0] pe_done,
  output logic               busy,
  output logic               job_done
);

  localparam int PROD_W = COL_W + CNT_W;

  state_e             state_d, state_q;
  logic [COL_W-1:0]   col_d, col_q;
  logic [COL_W-1:0]   last_col_d, last_col_q;
  logic [CNT_W-1:0]   ch_d, ch_q;
  logic [CNT_W-1:0]   chans_d, chans_q;
  logic [IMG_ROW-1:0] sticky_d, sticky_q;

  logic               start_strobe_s;
  logic               clear_strobe_s;
  logic               flush_start_s;
  logic [PROD_W-1:0]  lin_addr_s;

  // Next-state, counter and sticky-done logic; abort overrides every state but IDLE.
  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    last_col_d     = last_col_q;
    ch_d           = ch_q;
    chans_d        = chans_q;
    sticky_d       = sticky_q;
    start_strobe_s = 1'b0;
    clear_strobe_s = 1'b0;
    flush_start_s  = 1'b0;

    if (cfg_abort && (state_q != ST_IDLE)) begin
      state_d        = ST_IDLE;
      col_d          = '0;
      ch_d           = '0;
      sticky_d       = '0;
      flush_start_s  = 1'b1;
      clear_strobe_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_start) begin
            state_d    = ST_CLEAR;
            chans_d    = chan_count(channel_packed);
            last_col_d = (cfg_cols == '0) ? '0 : (cfg_cols - COL_W'(1));
            sticky_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CLEAR: begin
          clear_strobe_s = 1'b1;
          col_d          = '0;
          ch_d           = '0;
          sticky_d       = sticky_q | pe_done;
          state_d        = ST_RUN;
        end
        ST_RUN: begin
          sticky_d = sticky_q | pe_done;
          if (buf_ready) begin
            start_strobe_s = 1'b1;
            if (ch_q == (chans_q - CNT_W'(1))) begin
              ch_d = '0;
              if (col_q == last_col_q) begin
                col_d   = '0;
                state_d = ST_DRAIN;
              end else begin
                col_d = col_q + COL_W'(1);
              end
            end else begin
              ch_d = ch_q + CNT_W'(1);
            end
          end else begin
            ch_d = ch_q;
          end
        end
        ST_DRAIN: begin
          sticky_d = sticky_q | pe_done;
          if (&sticky_q) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_FIN: begin
          sticky_d = '0;
          state_d  = ST_IDLE;
        end
        default: begin
          state_d  = ST_IDLE;
          col_d    = '0;
          ch_d     = '0;
          sticky_d = '0;
        end
      endcase
    end
  end

  // Control state, loop counters and latched job configuration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      last_col_q <= '0;
      ch_q       <= '0;
      chans_q    <= '0;
      sticky_q   <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      last_col_q <= last_col_d;
      ch_q       <= ch_d;
      chans_q    <= chans_d;
      sticky_q   <= sticky_d;
    end
  end

  // Linear image address; the product is wide enough that only the final cast wraps.
  always_comb begin
    lin_addr_s = PROD_W'(col_q) * PROD_W'(chans_q) + PROD_W'(ch_q);
  end

  assign rd_valid = (state_q == ST_RUN) && buf_ready;
  assign img_addr = ADDR_W'(lin_addr_s);
  assign wgt_addr = ADDR_W'(ch_q);
  assign busy     = (state_q != ST_IDLE);
  assign job_done = (state_q == ST_FIN);

  skew_line #(.DEPTH(IMG_ROW)) u_start_line (
    .clk   (clk),
    .rst_n (reset),
    .flush (flush_start_s),
    .din   (start_strobe_s),
    .taps  (pe_start)
  );

  skew_line #(.DEPTH(IMG_ROW)) u_clear_line (
    .clk   (clk),
    .rst_n (reset),
    .flush (1'b0),
    .din   (clear_strobe_s),
    .taps  (pe_clear)
  );

endmodule

// File: tb/tb_pe_conv_ctrl.sv
// Directed bench for pe_conv_ctrl with a 4-row array and 16-bit addresses.
module tb_pe_conv_ctrl;

  localparam int IMG_ROW = 4;
  localparam int COL_W   = 8;
  localparam int ADDR_W  = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_start;
  logic               cfg_abort;
  logic [2:0]         channel_packed;
  logic [COL_W-1:0]   cfg_cols;
  logic               buf_ready;
  logic               rd_valid;
  logic [ADDR_W-1:0]  img_addr;
  logic [ADDR_W-1:0]  wgt_addr;
  logic [IMG_ROW-1:0] pe_start;
  logic [IMG_ROW-1:0] pe_clear;
  logic [IMG_ROW-1:0] pe_done;
  logic               busy;
  logic               job_done;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  logic [3:0] run1_start [6] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF};
  logic [3:0] run1_clear [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
  logic [3:0] drn1_start [5] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

  always #5 clk = ~clk;

  pe_conv_ctrl #(.IMG_ROW(IMG_ROW), .COL_W(COL_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start      (cfg_start),
    .cfg_abort      (cfg_abort),
    .channel_packed (channel_packed),
    .cfg_cols       (cfg_cols),
    .buf_ready      (buf_ready),
    .rd_valid       (rd_valid),
    .img_addr       (img_addr),
    .wgt_addr       (wgt_addr),
    .pe_start       (pe_start),
    .pe_clear       (pe_clear),
    .pe_done        (pe_done),
    .busy           (busy),
    .job_done       (job_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic prev_br;
    int   exp_addr;

    reset = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; channel_packed = 3'd0;
    cfg_cols = 8'd0; buf_ready = 1'b0; pe_done = 4'h0;
    tick(); tick();
    chk("rst_ctrl", {busy, job_done, rd_valid}, 64'd0);
    chk("rst_skew", {pe_start, pe_clear}, 64'd0);
    chk("rst_addr", {img_addr, wgt_addr}, 64'd0);
    reset = 1'b1;
    tick();

    // Abort while idle must not inject a clear.
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
    chk("idle_abort_clear", pe_clear, 64'd0);
    chk("idle_abort_busy", busy, 64'd0);

    // Job 1: C=3, two columns, no stalls.
    buf_ready = 1'b1; channel_packed = 3'd0; cfg_cols = 8'd2;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    chk("j1_clear_busy", busy, 64'd1);
    chk("j1_clear_rdv", rd_valid, 64'd0);
    tick();
    for (int b = 0; b < 6; b++) begin
      chk("j1_rdv", rd_valid, 64'd1);
      chk("j1_img", img_addr, 64'(b));
      chk("j1_wgt", wgt_addr, 64'(b % 3));
      chk("j1_start", pe_start, run1_start[b]);
      chk("j1_clear", pe_clear, run1_clear[b]);
      tick();
    end
    for (int d = 0; d < 9; d++) begin
      chk("j1_drain_busy", busy, 64'd1);
      chk("j1_drain_done", job_done, 64'd0);
      chk("j1_drain_rdv", rd_valid, 64'd0);
      if (d < 5) chk("j1_drain_start", pe_start, drn1_start[d]);
      tick();
    end
    pe_done = 4'hF; tick(); pe_done = 4'h0;
    chk("j1_sticky_wait", job_done, 64'd0);
    tick();
    chk("j1_fin_done", job_done, 64'd1);
    chk("j1_fin_busy", busy, 64'd1);
    tick();
    chk("j1_idle_done", job_done, 64'd0);
    chk("j1_idle_busy", busy, 64'd0);

    // Job 2: C=8, one column, stalls on run cycles 3 and 5; stray done bit while idle.
    pe_done = 4'h1; tick(); pe_done = 4'h0;
    channel_packed = 3'd1; cfg_cols = 8'd1;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    tick();
    prev_br  = 1'b0;
    exp_addr = 0;
    for (int k = 0; k < 10; k++) begin
      buf_ready = !(k == 3 || k == 5);
      cfg_start = (k == 1);
      #1;
      chk("j2_rdv", rd_valid, 64'(buf_ready));
      chk("j2_img", img_addr, 64'(exp_addr));
      chk("j2_wgt", wgt_addr, 64'(exp_addr));
      chk("j2_start0", pe_start[0], 64'(prev_br));
      prev_br = buf_ready;
      if (buf_ready) exp_addr++;
      tick();
    end
    cfg_start = 1'b0; buf_ready = 1'b1; #1;
    chk("j2_drain_rdv", rd_valid, 64'd0);
    chk("j2_drain_start0", pe_start[0], 64'd1);
    pe_done = 4'h8; tick();
    pe_done = 4'h4; tick();
    pe_done = 4'h2; tick();
    chk("j2_partial_done", job_done, 64'd0);
    chk("j2_partial_busy", busy, 64'd1);
    pe_done = 4'h1; tick(); pe_done = 4'h0;
    chk("j2_last_bit_wait", job_done, 64'd0);
    tick();
    chk("j2_fin_done", job_done, 64'd1);
    tick();
    chk("j2_idle_busy", busy, 64'd0);

    // Job 3: abort on the fifth beat, then a fresh one-column job.
    channel_packed = 3'd0; cfg_cols = 8'd2;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    tick();
    for (int b = 0; b < 4; b++) tick();
    chk("j3_beat4_img", img_addr, 64'd4);
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
    chk("ab_busy", busy, 64'd0);
    chk("ab_rdv", rd_valid, 64'd0);
    chk("ab_start", pe_start, 64'd0);
    chk("ab_clear0", pe_clear, 64'd1);
    chk("ab_done", job_done, 64'd0);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("ab_clear_skew", pe_clear, (i < 4) ? (64'd1 << i) : 64'd0);
      chk("ab_no_done", job_done, 64'd0);
    end
    cfg_cols = 8'd1;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    tick();
    for (int b = 0; b < 3; b++) begin
      chk("j4_rdv", rd_valid, 64'd1);
      chk("j4_img", img_addr, 64'(b));
      tick();
    end
    chk("j4_drain_rdv", rd_valid, 64'd0);
    chk("j4_drain_start", pe_start, 64'h7);

    // Reset in DRAIN clears everything without waiting for a clock.
    reset = 1'b0; #1;
    chk("mid_rst_ctrl", {busy, job_done, rd_valid}, 64'd0);
    chk("mid_rst_skew", {pe_start, pe_clear}, 64'd0);
    chk("mid_rst_addr", {img_addr, wgt_addr}, 64'd0);
    #1; reset = 1'b1;
    tick();
    chk("post_rst_busy", busy, 64'd0);
    cfg_cols = 8'd0;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    tick();
    for (int b = 0; b < 3; b++) begin
      chk("c0_rdv", rd_valid, 64'd1);
      chk("c0_img", img_addr, 64'(b));
      tick();
    end
    chk("c0_drain_rdv", rd_valid, 64'd0);
    chk("c0_drain_busy", busy, 64'd1);
    pe_done = 4'hF; tick(); pe_done = 4'h0;
    tick();
    chk("c0_fin_done", job_done, 64'd1);
    tick();

    // Job 5: C=512, 255 columns; address wraps at beat 65536.
    channel_packed = 3'd7; cfg_cols = 8'd255;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    tick();
    chk("wr_beat0_img", img_addr, 64'd0);
    for (int n = 1; n < 65536; n++) begin
      tick();
      if (n == 513) begin
        chk("wr_beat513_img", img_addr, 64'd513);
        chk("wr_beat513_wgt", wgt_addr, 64'd1);
      end
    end
    chk("wr_top_img", img_addr, 64'hFFFF);
    chk("wr_top_wgt", wgt_addr, 64'h1FF);
    chk("wr_top_rdv", rd_valid, 64'd1);
    tick();
    chk("wr_wrap_img", img_addr, 64'd0);
    chk("wr_wrap_wgt", wgt_addr, 64'd0);
    chk("wr_wrap_rdv", rd_valid, 64'd1);
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
    chk("wr_abort_busy", busy, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
